// File: rtl/fft_peak_finder_if.sv
// Bundle between an FFT magnitude source / peak-report consumer and fft_peak_finder.
interface fft_peak_finder_if #(
    parameter int MAG_W = 28,
    parameter int BIN_W = 11
);
    logic [MAG_W-1:0] mag_in;
    logic [BIN_W-1:0] bin_in;
    logic             mag_valid;
    logic [MAG_W-1:0] threshold;
    logic             ready_for_frame;
    logic             peak_valid;
    logic             peak_ready;
    logic [3:0]       peak_rank;
    logic [BIN_W-1:0] peak_bin;
    logic [MAG_W-1:0] peak_mag;
    logic             peak_found;
    logic             peak_last;
    logic [4:0]       peak_count;
    logic             frame_dropped;

    modport slave (
        input  mag_in, bin_in, mag_valid, threshold, peak_ready,
        output ready_for_frame, peak_valid, peak_rank, peak_bin, peak_mag,
               peak_found, peak_last, peak_count, frame_dropped
    );

    modport master (
        output mag_in, bin_in, mag_valid, threshold, peak_ready,
        input  ready_for_frame, peak_valid, peak_rank, peak_bin, peak_mag,
               peak_found, peak_last, peak_count, frame_dropped
    );
endinterface

// File: rtl/fft_peak_finder.sv
// Streaming top-K local-maximum finder over one FFT frame; reports the
// sorted peak list over a valid/ready channel.
module fft_peak_finder #(
    parameter int MAG_W     = 28,
    parameter int N_FFT     = 2048,
    parameter int NUM_PEAKS = 2,
    parameter int MIN_BIN   = 1,
    parameter int MAX_BIN   = N_FFT / 2 - 1,
    localparam int BIN_W    = $clog2(N_FFT)
) (
    input  logic             clk,
    input  logic             rst,
    fft_peak_finder_if.slave pf
);
    localparam int IDX_W = (NUM_PEAKS > 1) ? $clog2(NUM_PEAKS) : 1;
    localparam logic [BIN_W-1:0] MIN_B    = BIN_W'(MIN_BIN);
    localparam logic [BIN_W-1:0] MAX_B    = BIN_W'(MAX_BIN);
    localparam logic [BIN_W-1:0] LAST_B   = BIN_W'(N_FFT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PEAKS - 1);
    localparam logic [4:0]       K5       = 5'(NUM_PEAKS);

    typedef enum logic [1:0] {IDLE, COLLECT, FINISH, REPORT} state_t;
    state_t state_q;

    logic [MAG_W-1:0] thr_q, m0_q, m1_q;
    logic [BIN_W-1:0] b0_q;
    logic             cand_vld_q;
    logic [MAG_W-1:0] cand_mag_q;
    logic [BIN_W-1:0] cand_bin_q;

    logic [NUM_PEAKS-1:0]            lv_q, lv_d;
    logic [NUM_PEAKS-1:0][MAG_W-1:0] lm_q, lm_d;
    logic [NUM_PEAKS-1:0][BIN_W-1:0] lb_q, lb_d;
    logic [NUM_PEAKS-1:0]            ge;
    logic [4:0]                      cnt_q, cnt_d;

    logic [IDX_W-1:0] idx_q, idx_nx;
    logic             rdy_q, pv_q, pfound_q, plast_q, drop_q;
    logic [BIN_W-1:0] pbin_q;
    logic [MAG_W-1:0] pmag_q;
    logic [4:0]       pcnt_q;

    logic bin0, start, is_peak;
    assign bin0  = pf.mag_valid && (pf.bin_in == '0);
    assign start = bin0 && (state_q == IDLE || state_q == COLLECT);
    // m0_q becomes the candidate centre: left neighbour m1_q, right neighbour the incoming sample.
    assign is_peak = (m0_q > m1_q) && (m0_q >= pf.mag_in) && (m0_q >= thr_q)
                  && (b0_q >= MIN_B) && (b0_q <= MAX_B);
    assign idx_nx  = idx_q + IDX_W'(1);
    assign cnt_d   = cnt_q + 5'(cand_vld_q && (cnt_q < K5));

    // Parallel sorted insert: a slot is kept if it is at least as large as the newcomer.
    always_comb begin
        lv_d = lv_q;
        lm_d = lm_q;
        lb_d = lb_q;
        for (int i = 0; i < NUM_PEAKS; i++) ge[i] = lv_q[i] && (lm_q[i] >= cand_mag_q);
        if (cand_vld_q) begin
            for (int i = NUM_PEAKS - 1; i >= 1; i--) begin
                if (!ge[i]) begin
                    if (ge[i-1]) begin
                        lv_d[i] = 1'b1;
                        lm_d[i] = cand_mag_q;
                        lb_d[i] = cand_bin_q;
                    end else begin
                        lv_d[i] = lv_q[i-1];
                        lm_d[i] = lm_q[i-1];
                        lb_d[i] = lb_q[i-1];
                    end
                end
            end
            if (!ge[0]) begin
                lv_d[0] = 1'b1;
                lm_d[0] = cand_mag_q;
                lb_d[0] = cand_bin_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            thr_q      <= '0;
            m0_q       <= '0;
            m1_q       <= '0;
            b0_q       <= '0;
            cand_vld_q <= 1'b0;
            cand_mag_q <= '0;
            cand_bin_q <= '0;
            lv_q       <= '0;
            lm_q       <= '0;
            lb_q       <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            rdy_q      <= 1'b1;
            pv_q       <= 1'b0;
            pfound_q   <= 1'b0;
            pbin_q     <= '0;
            pmag_q     <= '0;
            plast_q    <= 1'b0;
            pcnt_q     <= '0;
            drop_q     <= 1'b0;
        end else begin
            drop_q <= 1'b0;
            case (state_q)
                IDLE: ;
                COLLECT: begin
                    lv_q       <= lv_d;
                    lm_q       <= lm_d;
                    lb_q       <= lb_d;
                    cnt_q      <= cnt_d;
                    cand_vld_q <= 1'b0;
                    if (pf.mag_valid) begin
                        m1_q       <= m0_q;
                        m0_q       <= pf.mag_in;
                        b0_q       <= pf.bin_in;
                        cand_vld_q <= is_peak;
                        cand_mag_q <= m0_q;
                        cand_bin_q <= b0_q;
                        if (pf.bin_in == LAST_B) begin
                            state_q <= FINISH;
                            rdy_q   <= 1'b0;
                        end
                    end
                end
                FINISH: begin
                    lv_q       <= lv_d;
                    lm_q       <= lm_d;
                    lb_q       <= lb_d;
                    cnt_q      <= cnt_d;
                    cand_vld_q <= 1'b0;
                    pv_q       <= 1'b1;
                    idx_q      <= '0;
                    pfound_q   <= lv_d[0];
                    pbin_q     <= lb_d[0];
                    pmag_q     <= lm_d[0];
                    plast_q    <= (LAST_IDX == '0);
                    pcnt_q     <= cnt_d;
                    drop_q     <= bin0;
                    state_q    <= REPORT;
                end
                REPORT: begin
                    drop_q <= bin0;
                    if (pv_q && pf.peak_ready) begin
                        if (plast_q) begin
                            state_q  <= IDLE;
                            rdy_q    <= 1'b1;
                            pv_q     <= 1'b0;
                            idx_q    <= '0;
                            pfound_q <= 1'b0;
                            pbin_q   <= '0;
                            pmag_q   <= '0;
                            plast_q  <= 1'b0;
                            pcnt_q   <= '0;
                        end else begin
                            idx_q    <= idx_nx;
                            pfound_q <= lv_q[idx_nx];
                            pbin_q   <= lb_q[idx_nx];
                            pmag_q   <= lm_q[idx_nx];
                            plast_q  <= (idx_nx == LAST_IDX);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
            // Bin 0 in IDLE or COLLECT (re)starts a frame and overrides the above.
            if (start) begin
                state_q    <= COLLECT;
                thr_q      <= pf.threshold;
                m1_q       <= '0;
                m0_q       <= pf.mag_in;
                b0_q       <= '0;
                cand_vld_q <= 1'b0;
                lv_q       <= '0;
                lm_q       <= '0;
                lb_q       <= '0;
                cnt_q      <= '0;
            end
        end
    end

    assign pf.ready_for_frame = rdy_q;
    assign pf.peak_valid      = pv_q;
    assign pf.peak_rank       = 4'(idx_q);
    assign pf.peak_bin        = pbin_q;
    assign pf.peak_mag        = pmag_q;
    assign pf.peak_found      = pfound_q;
    assign pf.peak_last       = plast_q;
    assign pf.peak_count      = pcnt_q;
    assign pf.frame_dropped   = drop_q;
endmodule
